bram_port_arbiter: RTL and testbench

- Shares the single read/write port (port B) of the on-chip block-RAM cache between two bus masters.
- M0 is the CPU data bus; M1 is the SD-sector copy engine that moves the 512-byte SD cache window into RAM.
- Grants one master at a time, sequences the access, absorbs the fixed BRAM read latency, and returns a one-cycle done pulse to the master it served.
- Replaces ad-hoc step counters in the top-level bus process.

---
 rtl/bram_port_arbiter.sv | 145 ++++++++++++++
 tb/tb_bram_port_arbiter.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// Two-master arbiter for the shared block-RAM port B (CPU data bus, SD copy engine).
// Optional BRAM_ARB_ROUND_ROBIN_EN: ties go to the master not served last.
module bram_port_arbiter #(
    parameter int AW     = 16,
    parameter int DW     = 32,
    parameter int RD_LAT = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          m0_req,
    input  logic          m0_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [DW-1:0] m0_wdata,
    output logic          m0_done,
    input  logic          m1_req,
    input  logic          m1_we,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m1_wdata,
    output logic          m1_done,
    output logic [DW-1:0] rdata,
    output logic [AW-3:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy,
    output logic [1:0]    owner
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [2:0] LAT_LOAD = 3'(RD_LAT - 1);

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic            we_q, we_d;
    logic [AW-3:0]   addr_q, addr_d;
    logic [DW-1:0]   wdata_q, wdata_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            grant_m1;
    logic [AW-1:0]   req_addr;
    logic            unused_addr_bits;

`ifdef BRAM_ARB_ROUND_ROBIN_EN
    logic            last_q, last_d;

    // last_q=1 means M1 was served last, so a tie then goes to M0
    assign grant_m1 = m1_req && (!m0_req || !last_q);
`else
    assign grant_m1 = m1_req && !m0_req;
`endif

    assign req_addr         = grant_m1 ? m1_addr : m0_addr;
    assign unused_addr_bits = ^{m0_addr[1:0], m1_addr[1:0]};

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        cnt_d   = cnt_q;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        unique case (state_q)
            S_IDLE: begin
                if (m0_req || m1_req) begin
                    sel_d   = grant_m1;
                    we_d    = grant_m1 ? m1_we : m0_we;
                    wdata_d = grant_m1 ? m1_wdata : m0_wdata;
                    addr_d  = req_addr[AW-1:2];
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: begin
                if (we_q) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d   = LAT_LOAD;
                    state_d = S_WAIT;
                end
            end
            // count reaches zero in the cycle mem_rdata is valid
            S_WAIT: begin
                if (cnt_q == 3'd0) begin
                    rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_DONE: begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
                last_d  = sel_q;
`endif
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            cnt_q   <= 3'd0;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            cnt_q   <= cnt_d;
`ifdef BRAM_ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    // strobe decoded from state so reset removes it asynchronously
    assign mem_we    = (state_q == S_ACCESS) && we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign rdata     = rdata_q;
    assign busy      = (state_q != S_IDLE);
    assign owner     = busy ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
    assign m0_done   = (state_q == S_DONE) && !sel_q;
    assign m1_done   = (state_q == S_DONE) && sel_q;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench for bram_port_arbiter: transaction-timeline model, directed cases, random traffic.
// Define BRAM_ARB_ROUND_ROBIN_EN for both files to check the round-robin build.
module tb_bram_port_arbiter;

    localparam int AW     = 16;
    localparam int DW     = 32;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          m0_req, m0_we, m0_done;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata;
    logic          m1_req, m1_we, m1_done;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata;
    logic [DW-1:0] rdata;
    logic [AW-3:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;
    logic [1:0]    owner;

    bram_port_arbiter #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_done(m0_done),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_done(m1_done),
        .rdata(rdata), .mem_addr(mem_addr), .mem_we(mem_we),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .busy(busy), .owner(owner)
    );

    always #5 clk = ~clk;

    // BRAM with a RD_LAT-deep read pipeline and a bench load port
    logic [31:0] bram [0:16383];
    logic [31:0] pipe [0:RD_LAT-1];
    logic        ld_we;
    logic [13:0] ld_addr;
    logic [31:0] ld_data;

    always @(posedge clk) begin
        if (ld_we) bram[ld_addr] <= ld_data;
        else if (mem_we) bram[mem_addr] <= mem_wdata;
        pipe[0] <= bram[mem_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign mem_rdata = pipe[RD_LAT-1];

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;

    // model state: one transaction described by its grant/done cycles
    logic [31:0] gold [0:16383];
    bit          act;
    bit          own;
    bit          c_we;
    logic [13:0] c_word;
    logic [31:0] c_wd;
    int          t_acc, t_done;
    bit          last_m1;
    logic [13:0] e_addr;
    logic [31:0] e_wd, e_rd;

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)",
                      nm, a, e, cyc);
    endtask

    task automatic check_all(input bit eb, input logic [1:0] eo,
                             input bit ew, input bit d0, input bit d1);
        chk("busy", 32'(busy), 32'(eb));
        chk("owner", 32'(owner), 32'(eo));
        chk("mem_we", 32'(mem_we), 32'(ew));
        chk("mem_addr", 32'(mem_addr), 32'(e_addr));
        chk("mem_wdata", mem_wdata, e_wd);
        chk("m0_done", 32'(m0_done), 32'(d0));
        chk("m1_done", 32'(m1_done), 32'(d1));
        chk("rdata", rdata, e_rd);
    endtask

    task automatic model_loop();
        bit eb, ew, d0, d1, g;
        logic [1:0]  eo;
        logic [15:0] a;
        forever begin
            @(negedge clk);
            cyc++;
            if (ld_we) gold[ld_addr] = ld_data;
            if (!reset) begin
                act = 0; last_m1 = 1;
                e_addr = '0; e_wd = '0; e_rd = '0;
                check_all(0, 2'b00, 0, 0, 0);
            end else begin
                eb = 0; ew = 0; d0 = 0; d1 = 0; eo = 2'b00;
                if (act) begin
                    eb = 1;
                    eo = own ? 2'b10 : 2'b01;
                    if (cyc == t_acc && c_we) begin
                        ew = 1;
                        gold[c_word] = c_wd;
                    end
                    if (cyc == t_done) begin
                        d0 = !own; d1 = own;
                        if (!c_we) e_rd = gold[c_word];
                        last_m1 = own;
                    end
                end
                check_all(eb, eo, ew, d0, d1);
                if (act && cyc == t_done) begin
                    act = 0;
                end else if (!act && (m0_req || m1_req)) begin
`ifdef BRAM_ARB_ROUND_ROBIN_EN
                    g = m1_req && (!m0_req || !last_m1);
`else
                    g = m1_req && !m0_req;
`endif
                    own    = g;
                    c_we   = g ? m1_we : m0_we;
                    a      = g ? m1_addr : m0_addr;
                    c_word = 14'(a >> 2);
                    c_wd   = g ? m1_wdata : m0_wdata;
                    e_addr = c_word;
                    e_wd   = c_wd;
                    act    = 1;
                    t_acc  = cyc + 1;
                    t_done = cyc + (c_we ? 2 : RD_LAT + 2);
                end
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [15:0] rnd_addr();
        logic [13:0] w;
        logic [1:0]  b;
        if ($urandom_range(0, 1) == 0) w = 14'($urandom_range(0, 63));
        else w = 14'(16'h3FC0 + 16'($urandom_range(0, 63)));
        b = 2'($urandom_range(0, 3));
        return {w, b};
    endfunction

    task automatic wait_done(input bit m, input int lim, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(m ? m1_done : m0_done) && n < lim);
    endtask

    task automatic finish_both();
        bit d0, d1;
        for (int k = 0; k < 60 && (m0_req || m1_req); k++) begin
            @(negedge clk);
            d0 = m0_done; d1 = m1_done;
            step();
            if (d0) m0_req = 0;
            if (d1) m1_req = 0;
        end
        chk("drain", 32'({m0_req, m1_req}), 32'd0);
    endtask

    int n;
    bit r0, r1;

    initial begin
        fork
            model_loop();
        join_none
        reset = 0; ld_we = 0; ld_addr = '0; ld_data = '0;
        m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;

        // preload under reset with the masters toggling randomly
        for (int i = 0; i < 130; i++) begin
            step();
            ld_we = 1;
            if (i < 64) ld_addr = 14'(i);
            else if (i < 128) ld_addr = 14'(16'h3FC0 + 16'(i - 64));
            else if (i == 128) ld_addr = 14'h0401;
            else ld_addr = 14'h0C00;
            ld_data = (i == 129) ? 32'h12345678 : $urandom;
            m0_req = 1'($urandom); m0_we = 1'($urandom);
            m0_addr = 16'($urandom); m0_wdata = $urandom;
            m1_req = 1'($urandom); m1_we = 1'($urandom);
            m1_addr = 16'($urandom); m1_wdata = $urandom;
        end
        step();
        ld_we = 0; m0_req = 0; m1_req = 0;
        step();
        reset = 1;
        repeat (6) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_owner", 32'(owner), 32'd0);

        // M0 write
        step();
        m0_we = 1; m0_addr = 16'h1004; m0_wdata = 32'hDEADBEEF; m0_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("wr_mem_addr", 32'(mem_addr), 32'h0401);
        chk("wr_mem_we", 32'(mem_we), 32'd1);
        chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
        chk("wr_owner", 32'(owner), 32'd1);
        @(negedge clk);
        chk("wr_done", 32'(m0_done), 32'd1);
        chk("wr_we_once", 32'(mem_we), 32'd0);
        chk("wr_rdata_kept", rdata, 32'd0);
        step();
        m0_req = 0; m0_addr = 16'($urandom); m0_wdata = $urandom;

        // M1 read of word 0x0C00
        step();
        m1_we = 0; m1_addr = 16'h3000; m1_req = 1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i == 1) begin
                chk("rd_mem_we", 32'(mem_we), 32'd0);
                chk("rd_owner", 32'(owner), 32'd2);
            end
            if (i == 3) chk("rd_early_done", 32'(m1_done), 32'd0);
            if (i == 4) begin
                chk("rd_done", 32'(m1_done), 32'd1);
                chk("rd_data", rdata, 32'h12345678);
                chk("rd_m0_quiet", 32'(m0_done), 32'd0);
            end
        end
        step();
        m1_req = 0;

        // simultaneous requests
        step();
        m0_we = 0; m0_addr = 16'h0014; m0_req = 1;
        m1_we = 1; m1_addr = 16'h001C; m1_wdata = 32'hCAFE0007; m1_req = 1;
        @(negedge clk);
        @(negedge clk);
        chk("tie_first", 32'(owner), 32'd1);
        wait_done(0, 20, n);
        chk("tie_m0_lat", 32'(n), 32'd3);
        chk("tie_m0_data", rdata, gold[5]);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("tie_gap", 32'(busy), 32'd0);
        @(negedge clk);
        chk("tie_second", 32'(owner), 32'd2);
        wait_done(1, 20, n);
        chk("tie_m1_lat", 32'(n), 32'd1);
        step();
        m1_req = 0;

        // M1 raised while M0 read is waiting
        step();
        m0_we = 0; m0_addr = 16'h0018; m0_req = 1;
        @(negedge clk);
        @(negedge clk);
        step();
        m1_we = 1; m1_addr = 16'h0020; m1_wdata = $urandom; m1_req = 1;
        @(negedge clk);
        chk("late_own_a", 32'(owner), 32'd1);
        @(negedge clk);
        chk("late_own_b", 32'(owner), 32'd1);
        @(negedge clk);
        chk("late_m0_done", 32'(m0_done), 32'd1);
        step();
        m0_req = 0;
        @(negedge clk);
        chk("late_idle", 32'(owner), 32'd0);
        @(negedge clk);
        chk("late_m1_acc", 32'(owner), 32'd2);
        chk("late_m1_we", 32'(mem_we), 32'd1);
        wait_done(1, 20, n);
        chk("late_m1_lat", 32'(n), 32'd1);
        step();
        m1_req = 0;

        // tie right after M0 was served
        step();
        m0_we = 1; m0_addr = 16'h0020; m0_wdata = $urandom; m0_req = 1;
        wait_done(0, 20, n);
        chk("solo_wr_lat", 32'(n), 32'd3);
        step();
        m0_req = 0;
        step();
        m0_we = 0; m0_addr = 16'h0024; m0_req = 1;
        m1_we = 0; m1_addr = 16'h0028; m1_req = 1;
        @(negedge clk);
        @(negedge clk);
`ifdef BRAM_ARB_ROUND_ROBIN_EN
        chk("tie_after_m0", 32'(owner), 32'd2);
`else
        chk("tie_after_m0", 32'(owner), 32'd1);
`endif
        finish_both();

        // reset during a write strobe
        step();
        m0_we = 1; m0_addr = 16'h002C; m0_wdata = 32'h0BAD0BAD; m0_req = 1;
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_wr_pre", 32'(mem_we), 32'd1);
        reset = 0; m0_req = 0;
        #1;
        chk("rst_wr_we", 32'(mem_we), 32'd0);
        chk("rst_wr_busy", 32'(busy), 32'd0);
        @(negedge clk);
        step();
        reset = 1;

        // reset during a read wait
        step();
        m0_we = 0; m0_addr = 16'h0030; m0_req = 1;
        @(negedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        chk("rst_rd_pre", 32'(busy), 32'd1);
        reset = 0; m0_req = 0;
        #1;
        chk("rst_rd_busy", 32'(busy), 32'd0);
        chk("rst_rd_owner", 32'(owner), 32'd0);
        chk("rst_rd_done", 32'(m0_done), 32'd0);
        repeat (2) @(negedge clk);
        step();
        reset = 1;
        step();
        m0_we = 0; m0_addr = 16'h002C; m0_req = 1;
        wait_done(0, 20, n);
        chk("post_rst_lat", 32'(n), 32'd5);
        chk("post_rst_data", rdata, gold[11]);
        step();
        m0_req = 0;

        // random traffic
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            r0 = m0_done; r1 = m1_done;
            step();
            if (m0_req && r0) m0_req = 0;
            else if (!m0_req && $urandom_range(0, 2) == 0) m0_req = 1;
            if (m1_req && r1) m1_req = 0;
            else if (!m1_req && $urandom_range(0, 2) == 0) m1_req = 1;
            m0_we = 1'($urandom); m0_addr = rnd_addr(); m0_wdata = $urandom;
            m1_we = 1'($urandom); m1_addr = rnd_addr(); m1_wdata = $urandom;
        end
        finish_both();
        repeat (3) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
